// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter: round-robin grant, one registered write per cycle.
// Optional `RF_ARB_ZERO_PROTECT_EN suppresses writes to register 0 while keeping the handshake.
module rf_write_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_wrt,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  sel_e              rr_ptr;
  logic              wr_en;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Readies are gated by rst_n so no grant is visible while reset is held.
  always_comb begin
    a_ready  = rst_n & a_valid & (~b_valid | (rr_ptr == SEL_A));
    b_ready  = rst_n & b_valid & (~a_valid | (rr_ptr == SEL_B));
    win_addr = a_ready ? a_addr : b_addr;
    win_data = a_ready ? a_data : b_data;
`ifdef RF_ARB_ZERO_PROTECT_EN
    wr_en    = (a_ready | b_ready) && (win_addr != '0);
`else
    wr_en    = a_ready | b_ready;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= SEL_A;
      rf_wrt       <= 1'b0;
      rf_rd        <= '0;
      rf_data_in   <= '0;
      conflict_cnt <= '0;
    end else begin
      rf_wrt <= wr_en;
      if (wr_en) begin
        rf_rd      <= win_addr;
        rf_data_in <= win_data;
      end
      // Pointer moves to whichever side was not served.
      if (a_ready)
        rr_ptr <= SEL_B;
      else if (b_ready)
        rr_ptr <= SEL_A;
      if (a_valid && b_valid && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed table, hand sequences, random vs. reference model.
module tb_rf_write_arbiter;

  logic        clk, rst_n;
  logic        a_valid, b_valid, a_ready, b_ready, rf_wrt;
  logic [5:0]  a_addr, b_addr, rf_rd;
  logic [31:0] a_data, b_data, rf_data_in;
  logic [15:0] conflict_cnt;

  int tests = 0;
  int fails = 0;

  rf_write_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_wrt(rf_wrt), .rf_rd(rf_rd), .rf_data_in(rf_data_in), .conflict_cnt(conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, summary follows");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

`ifdef RF_ARB_ZERO_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  // Reference model: who is owed the next tie, and what the register file sees.
  bit          m_owed_b;
  bit          m_wrt;
  logic [5:0]  m_rd;
  logic [31:0] m_data;
  int          m_cnt;
  bit          m_ga, m_gb;
  logic        obs_ar, obs_br;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owed_b = 1'b0;
    m_wrt    = 1'b0;
    m_rd     = '0;
    m_data   = '0;
    m_cnt    = 0;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    #2;
    chk("rst_wrt", {63'd0, rf_wrt}, 64'd0);
    chk("rst_rd", {58'd0, rf_rd}, 64'd0);
    chk("rst_data", {32'd0, rf_data_in}, 64'd0);
    chk("rst_cnt", {48'd0, conflict_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock with current inputs; checks readies mid-cycle and registered outputs after the edge.
  task automatic cycle();
    bit        win_b;
    bit        any;
    logic [5:0] wa;
    any   = a_valid || b_valid;
    win_b = (a_valid && b_valid) ? m_owed_b : !a_valid;
    m_ga  = any && !win_b;
    m_gb  = any && win_b;
    @(negedge clk);
    obs_ar = a_ready;
    obs_br = b_ready;
    chk("a_ready", {63'd0, a_ready}, {63'd0, m_ga});
    chk("b_ready", {63'd0, b_ready}, {63'd0, m_gb});
    @(posedge clk);
    if (a_valid && b_valid && m_cnt < 65535) m_cnt++;
    wa = win_b ? b_addr : a_addr;
    m_wrt = any && !(PROTECT && wa == 6'd0);
    if (m_wrt) begin
      m_rd   = wa;
      m_data = win_b ? b_data : a_data;
    end
    if (any) m_owed_b = !win_b;
    #1;
    chk("rf_wrt", {63'd0, rf_wrt}, {63'd0, m_wrt});
    chk("rf_rd", {58'd0, rf_rd}, {58'd0, m_rd});
    chk("rf_data_in", {32'd0, rf_data_in}, {32'd0, m_data});
    chk("conflict_cnt", {48'd0, conflict_cnt}, 64'(m_cnt));
  endtask

  typedef struct {
    bit          rst;
    logic        av;
    logic [5:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [5:0]  ba;
    logic [31:0] bd;
    logic        ear, ebr, ewrt;
    logic [5:0]  erd;
    logic [31:0] edata;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl[11];
  bit   a_hold, b_hold;

  initial begin
    // Single A write, then idle hold.
    tbl[0]  = '{1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd5, 32'hDEADBEEF, 16'd0};
    // Both held from reset: A,B,A,B.
    tbl[2]  = '{1'b1, 1'b1, 6'd1, 32'h11, 1'b1, 6'd2, 32'h22, 1'b1, 1'b0, 1'b1, 6'd1, 32'h11, 16'd1};
    tbl[3]  = '{1'b0, 1'b1, 6'd1, 32'h11, 1'b1, 6'd2, 32'h22, 1'b0, 1'b1, 1'b1, 6'd2, 32'h22, 16'd2};
    tbl[4]  = '{1'b0, 1'b1, 6'd1, 32'h11, 1'b1, 6'd2, 32'h22, 1'b1, 1'b0, 1'b1, 6'd1, 32'h11, 16'd3};
    tbl[5]  = '{1'b0, 1'b1, 6'd1, 32'h11, 1'b1, 6'd2, 32'h22, 1'b0, 1'b1, 1'b1, 6'd2, 32'h22, 16'd4};
    tbl[6]  = '{1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd2, 32'h22, 16'd4};
    // Same address: A first, B later, last write wins.
    tbl[7]  = '{1'b1, 1'b1, 6'd7, 32'h1, 1'b1, 6'd7, 32'h2, 1'b1, 1'b0, 1'b1, 6'd7, 32'h1, 16'd1};
    tbl[8]  = '{1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd7, 32'h2, 1'b0, 1'b1, 1'b1, 6'd7, 32'h2, 16'd1};
    tbl[9]  = '{1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd7, 32'h2, 16'd1};
`ifdef RF_ARB_ZERO_PROTECT_EN
    tbl[10] = '{1'b1, 1'b1, 6'd0, 32'h55, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 16'd0};
`else
    tbl[10] = '{1'b1, 1'b1, 6'd0, 32'h55, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd0, 32'h55, 16'd0};
`endif

    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_a_ready_low", {63'd0, a_ready}, 64'd0);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) do_reset();
      a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
      cycle();
      chk($sformatf("tbl%0d_ar", i), {63'd0, obs_ar}, {63'd0, tbl[i].ear});
      chk($sformatf("tbl%0d_br", i), {63'd0, obs_br}, {63'd0, tbl[i].ebr});
      chk($sformatf("tbl%0d_wrt", i), {63'd0, rf_wrt}, {63'd0, tbl[i].ewrt});
      chk($sformatf("tbl%0d_rd", i), {58'd0, rf_rd}, {58'd0, tbl[i].erd});
      chk($sformatf("tbl%0d_data", i), {32'd0, rf_data_in}, {32'd0, tbl[i].edata});
      chk($sformatf("tbl%0d_cnt", i), {48'd0, conflict_cnt}, {48'd0, tbl[i].ecnt});
    end

    // Reset arriving while an accepted write is being presented.
    do_reset();
    a_valid = 1'b1; a_addr = 6'd9; a_data = 32'h99;
    @(posedge clk);
    #1;
    chk("mid_wrt_before", {63'd0, rf_wrt}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_wrt_async", {63'd0, rf_wrt}, 64'd0);
    chk("mid_rd_async", {58'd0, rf_rd}, 64'd0);
    chk("mid_ready_in_rst", {63'd0, a_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("mid_no_write", {63'd0, rf_wrt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_edge_ready", {63'd0, a_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("first_edge_wrt", {63'd0, rf_wrt}, 64'd1);
    chk("first_edge_rd", {58'd0, rf_rd}, 64'd9);

    // Conflict counter saturation.
    do_reset();
    a_valid = 1'b1; a_addr = 6'd3; a_data = 32'h3;
    b_valid = 1'b1; b_addr = 6'd4; b_data = 32'h4;
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt_below_sat", {48'd0, conflict_cnt}, 64'd65534);
    repeat (70000 - 65534) @(posedge clk);
    #1;
    chk("cnt_saturated", {48'd0, conflict_cnt}, 64'hFFFF);

    // Random traffic against the model; requesters hold until served.
    do_reset();
    a_hold = 1'b0;
    b_hold = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (!a_hold) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_addr  = 6'($urandom_range(0, 7));
        a_data  = $urandom;
      end
      if (!b_hold) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_addr  = 6'($urandom_range(0, 7));
        b_data  = $urandom;
      end
      cycle();
      a_hold = a_valid && !m_ga;
      b_hold = b_valid && !m_gb;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, register address width (64 registers).
REQ-002 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: port clk, input, 1, rising-edge clock.
REQ-004 Port rst_n SHALL be input, 1 bit: asynchronous active-low reset.
REQ-005 Ports a_valid, b_valid SHALL be inputs, 1 bit each: requester A/B holds a write request.
REQ-006 Ports a_addr, b_addr SHALL be inputs, ADDR_W bits each: destination register of the request.
REQ-007 Ports a_data, b_data SHALL be inputs, DATA_W bits each: write data of the request.
REQ-008 Ports a_ready, b_ready SHALL be outputs, 1 bit each: request accepted this cycle.
REQ-009 Port rf_wrt SHALL be output, 1 bit: write enable to the register file.
REQ-010 Port rf_rd SHALL be output, ADDR_W bits: write address to the register file.
REQ-011 Port rf_data_in SHALL be output, DATA_W bits: write data to the register file.
REQ-012 Port conflict_cnt SHALL be output, 16 bits: saturating count of cycles with both requests valid.

Function
REQ-013 A request SHALL be accepted in cycle N when valid and ready are both high at the rising edge ending cycle N.
REQ-014 a_ready SHALL be combinational: a_valid AND (NOT b_valid OR rr_ptr selects A). b_ready is symmetric.
REQ-015 At most one of a_ready/b_ready SHALL be high in any cycle.
REQ-016 Requesters SHALL hold valid, addr, data stable until ready; the block SHALL NOT buffer unaccepted requests.
REQ-017 The single-bit round-robin pointer rr_ptr SHALL update only on acceptance: it points to the non-granted requester.
REQ-018 With only one request valid, that request SHALL be granted regardless of rr_ptr, with no idle cycle.
REQ-019 An accepted request SHALL appear registered in cycle N+1: rf_wrt=1, rf_rd=addr, rf_data_in=data (latency 1).
REQ-020 In a cycle after no acceptance, rf_wrt SHALL be 0 and rf_rd/rf_data_in SHALL hold their last values.
REQ-021 Back-to-back acceptances SHALL sustain one write per cycle.
REQ-022 If both requests target the same address, the winner SHALL write first and the loser SHALL write in a later cycle, so the last write wins.
REQ-023 conflict_cnt SHALL increment by 1 on each cycle with a_valid and b_valid both high, and SHALL saturate at 16'hFFFF.

Reset
REQ-024 rst_n low SHALL immediately clear rf_wrt, rf_rd, rf_data_in and conflict_cnt to 0, and set rr_ptr to select A.
REQ-025 a_ready and b_ready SHALL be 0 while rst_n is low.
REQ-026 Requests accepted before reset but not yet issued SHALL be discarded by the reset.
REQ-027 The first edge after rst_n rises SHALL be able to accept a request.

Configuration
REQ-028 The macro RF_ARB_ZERO_PROTECT_EN SHALL compile in register-0 protection.
REQ-029 With the macro defined, accepted requests to address 0 SHALL complete the handshake normally and SHALL leave rf_wrt at 0 in N+1.
REQ-030 Without the macro, address 0 SHALL be written like any other address.

Verification
REQ-031 Reset, then hold a_valid=1, addr=5, data=32'hDEADBEEF for one cycle -> a_ready=1; next cycle rf_wrt=1, rf_rd=5, rf_data_in=32'hDEADBEEF.
REQ-032 Hold A and B valid for 4 cycles (addr 1, 2) from reset -> grants A,B,A,B; rf_rd sequence 1,2,1,2; conflict_cnt=4.
REQ-033 Both valid to addr 7, A=32'h1, B=32'h2 -> A writes first, then B; final rf_data_in=32'h2 at addr 7.
REQ-034 Assert rst_n low one cycle after acceptance -> rf_wrt=0 immediately and no write is issued.
REQ-035 Hold both valid for 70000 cycles -> conflict_cnt stops at 16'hFFFF.
REQ-036 With RF_ARB_ZERO_PROTECT_EN defined, request addr=0 -> a_ready=1 and rf_wrt stays 0; without the macro -> rf_wrt=1, rf_rd=0.
